// File: rtl/multiplier_arbiter_if.sv
// Requester, response and multiplier-side signals of multiplier_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface multiplier_arbiter_if #(
    parameter int WIDTH = 32
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;

    logic                 resp0_valid;
    logic                 resp0_ready;
    logic [2*WIDTH-1:0]   resp0_r;
    logic                 resp1_valid;
    logic                 resp1_ready;
    logic [2*WIDTH-1:0]   resp1_r;

    logic                 mul_valid_in;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_valid_out;
    logic [2*WIDTH-1:0]   mul_r;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  resp0_ready, resp1_ready, mul_valid_out, mul_r,
        output req0_ready, req1_ready, resp0_valid, resp0_r, resp1_valid, resp1_r,
        output mul_valid_in, mul_a, mul_b
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output resp0_ready, resp1_ready, mul_valid_out, mul_r,
        input  req0_ready, req1_ready, resp0_valid, resp0_r, resp1_valid, resp1_r,
        input  mul_valid_in, mul_a, mul_b
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// Shares one iterative multiplier between two requesters, one operation in flight.
// Define MULTIPLIER_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.
module multiplier_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multiplier_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     op_a_reg;
    logic [WIDTH-1:0]     op_b_reg;
    logic [2*WIDTH-1:0]   res_reg;
    logic                 owner_reg;
    logic                 grant0;
    logic                 grant1;
    logic                 resp_take;

`ifdef MULTIPLIER_ARBITER_ROUND_ROBIN_EN
    logic                 last_reg;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE && !reset) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_reg);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_reg);
        end
    end
`else
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE && !reset) begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
        end
    end
`endif

    assign resp_take = owner_reg ? bus.resp1_ready : bus.resp0_ready;

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.mul_valid_in = (state_reg == ISSUE);
    assign bus.mul_a        = op_a_reg;
    assign bus.mul_b        = op_b_reg;
    assign bus.resp0_valid  = (state_reg == DONE) && !owner_reg;
    assign bus.resp1_valid  = (state_reg == DONE) && owner_reg;
    assign bus.resp0_r      = res_reg;
    assign bus.resp1_r      = res_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            owner_reg <= 1'b0;
`ifdef MULTIPLIER_ARBITER_ROUND_ROBIN_EN
            last_reg  <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a_reg  <= grant1 ? bus.req1_a : bus.req0_a;
                        op_b_reg  <= grant1 ? bus.req1_b : bus.req0_b;
                        owner_reg <= grant1;
`ifdef MULTIPLIER_ARBITER_ROUND_ROBIN_EN
                        last_reg  <= grant1;
`endif
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= BUSY;
                end
                BUSY: begin
                    // Only the first high sample is taken; later cycles of a held strobe fall in DONE.
                    if (bus.mul_valid_out) begin
                        res_reg   <= bus.mul_r;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (resp_take) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter: expected products are queued per requester at
// each handshake and checked by a monitor when the response is consumed.
module tb_multiplier_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multiplier_arbiter_if #(.WIDTH(32)) bus();

    multiplier_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    int          grant_log[$];
    logic [31:0] exp_a = 0, exp_b = 0;
    int hs_cnt = 0, resp_cnt = 0, mvi_cnt = 0;
    int r0_rise = 0, r1_rise = 0, r0_cyc = 0;
    bit prev_mvi = 0, prev_r0v = 0, prev_r1v = 0;

    bit rand_rr = 0;
    logic rnd0 = 1'b0, rnd1 = 1'b0, fix0 = 1'b1, fix1 = 1'b1;
    assign bus.resp0_ready = rand_rr ? rnd0 : fix0;
    assign bus.resp1_ready = rand_rr ? rnd1 : fix1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit v, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Raises valid, waits for the grant, drops valid right after the handshake edge.
    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        set_req(p, 1'b1, a, b);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!reset && ((p == 0) ? bus.req0_ready : bus.req1_ready)) ok = 1;
        end
        tick();
        set_req(p, 1'b0, a, b);
        chk($sformatf("handshake_req%0d", p), ok, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp0.size() == 0 && exp1.size() == 0 && !bus.resp0_valid && !bus.resp1_valid) break;
        end
        chk("drain", 64'(exp0.size() + exp1.size()), 0);
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Behavioural multiplier: random latency, result strobe held for 1 or 2 cycles,
    // junk on mul_r whenever the strobe is low.
    logic        m_rst, m_vin, m_pend;
    logic [31:0] m_a, m_b;
    logic [63:0] m_prod;
    int          m_cnt, m_hold;
    initial begin
        bus.mul_valid_out = 1'b0;
        bus.mul_r = '0;
        m_pend = 0; m_cnt = 0; m_hold = 0; m_prod = '0;
        forever begin
            @(negedge clk);
            m_rst = reset; m_vin = bus.mul_valid_in; m_a = bus.mul_a; m_b = bus.mul_b;
            @(posedge clk);
            #1;
            if (m_rst) begin
                m_pend = 0; m_cnt = 0; m_hold = 0;
                bus.mul_valid_out = 1'b0;
            end else begin
                if (m_hold > 0) begin
                    m_hold--;
                    if (m_hold == 0) bus.mul_valid_out = 1'b0;
                end
                if (m_vin) begin
                    m_pend = 1;
                    m_cnt  = $urandom_range(1, 5);
                    m_prod = 64'(m_a) * 64'(m_b);
                end else if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_pend = 0;
                        bus.mul_valid_out = 1'b1;
                        m_hold = $urandom_range(1, 2);
                    end
                end
            end
            bus.mul_r = bus.mul_valid_out ? m_prod : {$urandom, $urandom};
        end
    end

    initial begin
        forever begin
            tick();
            rnd0 = 1'($urandom_range(0, 1));
            rnd1 = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            exp0.delete();
            exp1.delete();
            prev_mvi = 0; prev_r0v = 0; prev_r1v = 0;
        end else begin
            if (bus.req0_ready || bus.req1_ready)
                chk("one_grant", 64'(bus.req0_ready & bus.req1_ready), 0);
            if (bus.req0_valid && bus.req0_ready) begin
                exp0.push_back(64'(bus.req0_a) * 64'(bus.req0_b));
                grant_log.push_back(0);
                exp_a = bus.req0_a; exp_b = bus.req0_b;
                hs_cnt++;
                $display("[TB] grant req0 a=0x%08h b=0x%08h", bus.req0_a, bus.req0_b);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                exp1.push_back(64'(bus.req1_a) * 64'(bus.req1_b));
                grant_log.push_back(1);
                exp_a = bus.req1_a; exp_b = bus.req1_b;
                hs_cnt++;
                $display("[TB] grant req1 a=0x%08h b=0x%08h", bus.req1_a, bus.req1_b);
            end
            if (bus.mul_valid_in) begin
                mvi_cnt++;
                chk("mvi_single_cycle", 64'(prev_mvi), 0);
                chk("mul_a", 64'(bus.mul_a), 64'(exp_a));
                chk("mul_b", 64'(bus.mul_b), 64'(exp_b));
            end
            prev_mvi = bus.mul_valid_in;
            if (bus.resp0_valid || bus.resp1_valid)
                chk("one_resp", 64'(bus.resp0_valid & bus.resp1_valid), 0);
            if (bus.resp0_valid) r0_cyc++;
            if (bus.resp0_valid && !prev_r0v) r0_rise++;
            if (bus.resp1_valid && !prev_r1v) r1_rise++;
            prev_r0v = bus.resp0_valid;
            prev_r1v = bus.resp1_valid;
            if (bus.resp0_valid && bus.resp0_ready) begin
                resp_cnt++;
                chk("resp0_pending", 64'(exp0.size() > 0), 1);
                if (exp0.size() > 0) chk("resp0_r", bus.resp0_r, exp0.pop_front());
                $display("[TB] resp0 r=0x%016h", bus.resp0_r);
            end
            if (bus.resp1_valid && bus.resp1_ready) begin
                resp_cnt++;
                chk("resp1_pending", 64'(exp1.size() > 0), 1);
                if (exp1.size() > 0) chk("resp1_r", bus.resp1_r, exp1.pop_front());
                $display("[TB] resp1 r=0x%016h", bus.resp1_r);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, b0, a1, b1;
        logic [63:0] held;
        bit seen;
        int hs_base, resp_base, dead;

        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req0_ready", 64'(bus.req0_ready), 0);
        chk("rst_req1_ready", 64'(bus.req1_ready), 0);
        chk("rst_resp_valid", 64'({bus.resp0_valid, bus.resp1_valid}), 0);
        chk("rst_mul_valid_in", 64'(bus.mul_valid_in), 0);
        chk("rst_mul_a", 64'(bus.mul_a), 0);
        chk("rst_mul_b", 64'(bus.mul_b), 0);
        tick();

        // Single request 3*5
        mvi_cnt = 0; r0_rise = 0; r1_rise = 0; r0_cyc = 0;
        issue(0, 32'd3, 32'd5);
        wait_drain(100);
        chk("single_mvi_count", 64'(mvi_cnt), 1);
        chk("single_resp0_rises", 64'(r0_rise), 1);
        chk("single_resp0_cycles", 64'(r0_cyc), 1);
        chk("single_resp1_rises", 64'(r1_rise), 0);

        // Contention from a fresh reset
        pulse_reset();
        grant_log.delete();
        set_req(0, 1'b1, 32'd7, 32'd9);
        set_req(1, 1'b1, 32'd2, 32'd11);
        for (int i = 0; i < 500 && grant_log.size() < 4; i++) @(negedge clk);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        wait_drain(100);
        chk("contention_grants", 64'(grant_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef MULTIPLIER_ARBITER_ROUND_ROBIN_EN
            chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(i % 2));
`else
            chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 0);
`endif
        end

        // Backpressure on response 1 while req0 waits
        fix1 = 1'b0;
        a1 = $urandom; b1 = $urandom; a0 = $urandom; b0 = $urandom;
        issue(1, a1, b1);
        set_req(0, 1'b1, a0, b0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.resp1_valid;
        end
        chk("bp_resp1_seen", 64'(seen), 1);
        held = bus.resp1_r;
        chk("bp_resp1_r", held, 64'(a1) * 64'(b1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_resp1_valid", 64'(bus.resp1_valid), 1);
            chk("bp_resp1_stable", bus.resp1_r, held);
            chk("bp_req0_ready", 64'(bus.req0_ready), 0);
        end
        tick();
        fix1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_accept_req0", 64'(bus.req0_ready), 1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0);
        wait_drain(100);

        // Operand stability with the largest operands
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            bus.req0_a = $urandom;
            bus.req0_b = $urandom;
            @(negedge clk);
            if (bus.resp0_valid) begin
                seen = 1;
                chk("max_product", bus.resp0_r, 64'hFFFF_FFFE_0000_0001);
            end else begin
                chk("stable_mul_a", 64'(bus.mul_a), 64'hFFFF_FFFF);
                chk("stable_mul_b", 64'(bus.mul_b), 64'hFFFF_FFFF);
            end
            tick();
        end
        chk("stability_resp_seen", 64'(seen), 1);
        wait_drain(100);

        // Reset while BUSY
        issue(0, $urandom, $urandom);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r0_rise = 0; r1_rise = 0;
        @(negedge clk);
        chk("abort_mul_a", 64'(bus.mul_a), 0);
        chk("abort_queue_flushed", 64'(exp0.size()), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_resp", 64'(r0_rise + r1_rise), 0);
        tick();
        issue(1, $urandom, $urandom);
        wait_drain(100);

        // Random sweep: 100 operations, random gaps and response backpressure
        hs_base = hs_cnt;
        resp_base = resp_cnt;
        rand_rr = 1;
        fork
            begin
                for (int n = 0; n < 50; n++) begin
                    dead = $urandom_range(0, 12);
                    repeat (dead) tick();
                    issue(0, $urandom, $urandom);
                end
            end
            begin
                for (int n = 0; n < 50; n++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    issue(1, $urandom, $urandom);
                end
            end
        join
        rand_rr = 0;
        wait_drain(500);
        chk("sweep_handshakes", 64'(hs_cnt - hs_base), 100);
        chk("sweep_responses", 64'(resp_cnt - resp_base), 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
